// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect input and decode handshake.
interface fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic [31:0]     i_imem_rdata;
  logic            i_redirect_valid;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_valid;
  logic            i_ready;
  logic [31:0]     o_instr;
  logic [6:0]      o_opcode;
  logic [XLEN-1:0] o_pc;

  modport master (
    output o_imem_req, o_imem_addr, o_valid, o_instr, o_opcode, o_pc,
    input  i_imem_rdata, i_redirect_valid, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_valid, o_instr, o_opcode, o_pc,
    output i_imem_rdata, i_redirect_valid, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small instruction buffer; synchronous flush takes priority over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     din,
  output entry_t                     dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, 1-cycle imem reads, buffered hand-off to decode.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input logic      i_clk,
  input logic      i_rst_n,
  fetch_if.master  bus
);
  import fetch_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned OW = CW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            pop;
  logic            push;
  logic            issue;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [OW-1:0]   occupancy;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign pop       = bus.o_valid && bus.i_ready;
  // Slots already claimed once this cycle's pop is credited; bounds issue so a push never overflows.
  assign occupancy = {1'b0, count} + OW'(inflight) - OW'(pop);
  assign issue     = i_rst_n && !bus.i_redirect_valid && (occupancy < OW'(DEPTH));
  assign push      = inflight && !bus.i_redirect_valid && (!full || pop);

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = inflight_pc;
    wr_entry.instr = bus.i_imem_rdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.i_redirect_valid) begin
      fetch_pc <= {bus.i_redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc    <= fetch_pc + XLEN'(INSTR_BYTES);
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.i_redirect_valid),
    .din   (wr_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.o_imem_req  = issue;
  assign bus.o_imem_addr = fetch_pc;
  assign bus.o_valid     = !empty && !bus.i_redirect_valid;
  assign bus.o_instr     = head.instr;
  assign bus.o_opcode    = head.instr[6:0];
  assign bus.o_pc        = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC streams queued per redirect/reset, monitor pops on handshake.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          SEG_LEN = 128;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic        redirect;
  logic [31:0] rpc;
  logic [31:0] rdata = '0;
  bit          mode;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [31:0] exp_req_pc;

  fetch_if #(.XLEN(32)) bus ();

  assign bus.i_ready          = ready;
  assign bus.i_redirect_valid = redirect;
  assign bus.i_redirect_pc    = rpc;
  assign bus.i_imem_rdata     = rdata;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a, input bit m);
    return m ? ((a * 32'h9E37_79B1) ^ 32'h00A1_0093) : (a >> 2);
  endfunction

  // Synchronous instruction memory with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.o_imem_req) rdata <= word_of(bus.o_imem_addr, mode);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic new_stream(input logic [31:0] start);
    logic [31:0] p;
    exp_t e;
    p = {start[31:2], 2'b00};
    exp_q.delete();
    exp_req_pc = p;
    for (int i = 0; i < SEG_LEN; i++) begin
      e.pc    = p;
      e.instr = word_of(p, mode);
      exp_q.push_back(e);
      p = p + 32'd4;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  64'(bus.o_valid),     64'd0);
    check({tag, "_req"},    64'(bus.o_imem_req),  64'd0);
    check({tag, "_instr"},  64'(bus.o_instr),     64'd0);
    check({tag, "_pc"},     64'(bus.o_pc),        64'd0);
    check({tag, "_opcode"}, 64'(bus.o_opcode),    64'd0);
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(3))
      0:       return 32'hFFFF_FFF0 | (r & 32'hF);
      1:       return r & 32'h0000_03FF;
      default: return r;
    endcase
  endfunction

  // Transaction-level model: delivered items = requests older than one cycle minus pops.
  int          outstanding = 0;
  bit          req_prev = 0;
  bit          hold_v = 0;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  always @(negedge clk) begin
    bit   exp_valid, exp_pop, exp_req;
    exp_t e;
    if (!rst_n) begin
      outstanding = 0;
      req_prev    = 0;
      hold_v      = 0;
    end else if (redirect) begin
      check("redir_valid", 64'(bus.o_valid),    64'd0);
      check("redir_req",   64'(bus.o_imem_req), 64'd0);
      outstanding = 0;
      req_prev    = 0;
      hold_v      = 0;
    end else begin
      exp_valid = (outstanding - int'(req_prev)) > 0;
      exp_pop   = exp_valid && ready;
      exp_req   = (outstanding - int'(exp_pop)) < int'(DEPTH);
      check("valid", 64'(bus.o_valid),    64'(exp_valid));
      check("req",   64'(bus.o_imem_req), 64'(exp_req));
      if (exp_req) begin
        check("imem_addr", 64'(bus.o_imem_addr), 64'(exp_req_pc));
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (hold_v) begin
        check("hold_pc",    64'(bus.o_pc),    64'(hold_pc));
        check("hold_instr", 64'(bus.o_instr), 64'(hold_instr));
      end
      if (exp_pop) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard_empty: got pop with pc %0h expected no entry at %0t", bus.o_pc, $time);
        end else begin
          e = exp_q.pop_front();
          check("pc",     64'(bus.o_pc),     64'(e.pc));
          check("instr",  64'(bus.o_instr),  64'(e.instr));
          check("opcode", 64'(bus.o_opcode), 64'(e.instr[6:0]));
        end
      end
      outstanding = outstanding + int'(exp_req) - int'(exp_pop);
      req_prev    = exp_req;
      hold_v      = bus.o_valid && !ready;
      hold_pc     = bus.o_pc;
      hold_instr  = bus.o_instr;
    end
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int first_req, first_valid, pops, since;
    logic [31:0] t;
    rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; rpc = '0; mode = 1'b0;
    #12;
    check_zero("reset");

    // Sequential fetch from reset, imem data = addr>>2.
    @(posedge clk); #1;
    new_stream(RESET_PC);
    rst_n = 1'b1;
    first_req = -1; first_valid = -1; pops = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.o_imem_req && first_req < 0) first_req = c;
      if (bus.o_valid && first_valid < 0) first_valid = c;
      if (bus.o_valid && ready) pops++;
    end
    check("t1_first_req", 64'(first_req), 64'd0);
    check("t1_latency",   64'(first_valid - first_req), 64'd2);
    check("t1_rate",      64'(pops), 64'd10);

    // I-type word at address 0, decode stalled from the start.
    @(posedge clk); #1;
    rst_n = 1'b0; mode = 1'b1; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    new_stream(RESET_PC);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t2_valid",  64'(bus.o_valid),    64'd1);
    check("t2_pc",     64'(bus.o_pc),       64'd0);
    check("t2_instr",  64'(bus.o_instr),    64'h00A1_0093);
    check("t2_opcode", 64'(bus.o_opcode),   64'h13);
    check("t3_req",    64'(bus.o_imem_req), 64'd0);
    @(posedge clk); #1;
    ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Fill the buffer, then redirect.
    ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    ready = 1'b1; redirect = 1'b1; rpc = 32'h0000_0100;
    new_stream(32'h0000_0100);
    @(posedge clk); #1;
    redirect = 1'b0;
    first_valid = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.o_valid && first_valid < 0) first_valid = c;
    end
    check("t4_redir_latency", 64'(first_valid), 64'd3);

    // Unaligned target, then back-to-back redirects.
    @(posedge clk); #1;
    redirect = 1'b1; rpc = 32'h0000_0203;
    new_stream(32'h0000_0203);
    @(posedge clk); #1;
    redirect = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    redirect = 1'b1; rpc = 32'h0000_0040;
    new_stream(32'h0000_0040);
    @(posedge clk); #1;
    rpc = 32'h0000_0080;
    new_stream(32'h0000_0080);
    @(posedge clk); #1;
    redirect = 1'b0;
    repeat (8) @(posedge clk);

    // Reset while a response is outstanding.
    first_req = 0;
    for (int c = 0; c < 10 && first_req == 0; c++) begin
      @(negedge clk);
      if (bus.o_imem_req) first_req = 1;
    end
    check("t6_req_seen", 64'(first_req), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6_async");
    @(posedge clk); #1;
    new_stream(RESET_PC);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Randomized traffic: backpressure, redirects, occasional reset.
    since = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      redirect = 1'b0;
      ready    = ($urandom_range(3) != 0);
      if ($urandom_range(399) == 0) begin
        rst_n = 1'b0;
        #1;
        check_zero("rand_reset");
        @(posedge clk); #1;
        new_stream(RESET_PC);
        rst_n = 1'b1;
        since = 0;
      end else if (since > 90 || $urandom_range(15) == 0) begin
        t        = pick_target();
        mode     = bit'($urandom_range(1));
        redirect = 1'b1;
        rpc      = t;
        new_stream(t);
        since = 0;
      end else begin
        since++;
      end
    end
    @(posedge clk); #1;
    redirect = 1'b0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the RISC-V core. Sits directly upstream of decode/immediate_gen.
- Holds the PC and issues word reads to a synchronous 1-cycle-latency instruction memory.
- Buffers returned instructions in a small FIFO.
- Presents {pc, instr, opcode} to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes everything in flight.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC fetched first after reset
DEPTH, 2, instruction buffer entries (power of 2, >= 2)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
o_imem_req  output  1  read request this cycle
o_imem_addr  output  XLEN  word-aligned read address
i_imem_rdata  input  32  read data, valid the cycle after o_imem_req
i_redirect_valid  input  1  redirect PC (taken branch/jump)
i_redirect_pc  input  XLEN  redirect target
o_valid  output  1  instruction available to decode
i_ready  input  1  decode accepts
o_instr  output  32  instruction at buffer head
o_opcode  output  7  o_instr[6:0], drives immediate_gen i_opcode
o_pc  output  XLEN  PC of o_instr

Behaviour:
Reset (asynchronous, active-low):
- fetch_pc=RESET_PC, inflight=0, FIFO empty.
- o_valid=0, o_imem_req=0.
- o_instr, o_pc, o_opcode read 0.

Request issue (combinational):
- o_imem_req = !i_redirect_valid && (count + inflight - pop) < DEPTH, where pop = o_valid && i_ready.
- o_imem_addr = fetch_pc.
- On issue: fetch_pc <= fetch_pc+4 (wraps modulo 2^XLEN), inflight <= 1, inflight_pc <= fetch_pc.
- No issue: inflight <= 0.

Response:
- Cycle after an issue, if inflight=1 and not killed, push {inflight_pc, i_imem_rdata} at the clock edge.

Output:
- o_valid = !empty && !i_redirect_valid.
- Head fields shown combinationally.
- Pop on o_valid && i_ready.

Latency:
- Request in cycle k produces o_valid in cycle k+2. No bypass.
- Steady state with i_ready=1: one instruction per cycle.

Push and pop:
- Simultaneous push and pop with a full FIFO is legal. The count is unchanged.
- The issue rule guarantees a push never overflows.

Stall:
- i_ready=0 holds the head stable. o_valid stays 1.
- Requests stop once count+inflight = DEPTH.
- The PC is not advanced.

Redirect (i_redirect_valid=1 in cycle r):
- o_valid forced 0, so no pop in cycle r. o_imem_req=0.
- At edge r: FIFO cleared; fetch_pc <= {i_redirect_pc[XLEN-1:2],2'b00}. Low bits are ignored.
- At edge r: any response arriving in cycle r is discarded, and inflight <= 0.
- First request for the target goes out in cycle r+1. o_valid first rises in cycle r+3.
- Back-to-back redirects: the last one wins.

Reset mid-operation: all state returns to reset values immediately. The in-flight response is dropped.

No misalignment or access-fault reporting in this block.

Decomposition:
Package fetch_pkg:
- INSTR_BYTES=4
- fetch_entry_t struct {logic [XLEN-1:0] pc; logic [31:0] instr;}

Opcode constants stay in the existing opcodes header.

One sub-module: fetch_fifo.
- Parameters: DEPTH and the fetch_entry_t payload.
- Ports: push, pop, flush, full, empty, count.
- Synchronous flush.
- Flush has priority over push in the same cycle.

Test Plan:
1. Reset release, imem returns addr>>2 as data, i_ready=1 -> o_imem_addr 0,4,8,… on consecutive cycles; o_valid rises 2 cycles after first req; o_pc/o_instr pairs 0/0, 4/1, 8/2 in order; one per cycle.
2. I-type word 32'h00A1_0093 at addr 0 -> o_opcode=7'h13, o_instr=32'h00A1_0093, o_pc=0.
3. i_ready=0 from cycle 3 for 5 cycles -> head holds pc=0; o_imem_req drops after count+inflight=2; no pc skipped or duplicated after i_ready returns.
4. Redirect to 32'h0000_0100 while FIFO holds 2 entries and 1 in flight -> o_valid=0 in redirect cycle; next o_pc=0x100, then 0x104; stale PCs never appear.
5. Redirect to 32'h0000_0203 -> fetch restarts at 0x200; two redirects on consecutive cycles (0x40 then 0x80) -> first delivered o_pc=0x80.
6. i_rst_n pulsed low mid-stream with a request outstanding -> outputs zero asynchronously; after release, fetch restarts at RESET_PC and the old response is not delivered.
